// File: rtl/pht_access_ctrl.sv
// pht_access_ctrl
//   Shares the single-port pattern history table between fetch-side lookups
//   and resolve-side 2-bit counter updates. A lookup takes one table cycle.
//   An update is queued in a small FIFO. It is later applied as a
//   read-modify-write that takes two table cycles. This block is the only
//   driver of the table's write and address ports.
//
//   Build option: define PHT_INIT_EN to add an INIT sweep after reset. The
//   sweep writes 2'b01 (weakly not-taken) to every entry. With the macro
//   undefined the FSM enters IDLE directly and the table is left untouched.
//
//   Ports
//     clk, reset           clock; synchronous active-high reset
//     lk_valid/lk_ready    lookup handshake, with lk_set/lk_idx
//     lk_rsp_valid         one-cycle response strobe
//     lk_rsp_cnt           counter value read; lk_rsp_taken is its MSB
//     up_valid/up_ready    update handshake, with up_set/up_idx/up_taken
//     tab_wr_en            table write enable
//     tab_up_data          table write data
//     tab_set_addr         table set address
//     tab_tab_addr         table index address
//     tab_rd_data          table read data, one cycle after the address
//     busy                 FSM not in IDLE or update FIFO non-empty
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | arbitrate: full FIFO > lookup > pending update
//   S_UPD_RD | update address on table, counter being read
//   S_UPD_WR | saturated counter written back to the same address
//   S_INIT   | (PHT_INIT_EN only) sweep all entries with 2'b01
module pht_access_ctrl #(
  parameter int SET_W    = 2,
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int UQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [SET_W-1:0] lk_set,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_rsp_valid,
  output logic [CNT_W-1:0] lk_rsp_cnt,
  output logic             lk_rsp_taken,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [SET_W-1:0] up_set,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  output logic             tab_wr_en,
  output logic [CNT_W-1:0] tab_up_data,
  output logic [SET_W-1:0] tab_set_addr,
  output logic [IDX_W-1:0] tab_tab_addr,
  input  logic [CNT_W-1:0] tab_rd_data,
  output logic             busy
);

  localparam int PTR_W  = $clog2(UQ_DEPTH);
  localparam int ADDR_W = SET_W + IDX_W;
  localparam logic [PTR_W:0] UQ_FULL_CNT = (PTR_W + 1)'(UQ_DEPTH);

`ifdef PHT_INIT_EN
  typedef enum logic [1:0] {S_IDLE, S_UPD_RD, S_UPD_WR, S_INIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_UPD_RD, S_UPD_WR} state_t;
`endif

  state_t state_q, state_d;

  logic [SET_W-1:0] uq_set   [UQ_DEPTH];
  logic [IDX_W-1:0] uq_idx   [UQ_DEPTH];
  logic             uq_taken [UQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   uq_cnt_q;
  logic             uq_full, uq_empty, push, lk_go, upd_go;

  logic             hold_taken_q, tab_wr_en_q, rsp_pend_q, rsp_valid_q;
  logic [SET_W-1:0] tab_set_q;
  logic [IDX_W-1:0] tab_idx_q;
`ifdef PHT_INIT_EN
  logic [ADDR_W-1:0] init_cnt_q;
  logic              init_wr_q;
`endif

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                input logic taken);
    if (taken) return (cnt == '1) ? cnt : cnt + 1'b1;
    else       return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  assign uq_full  = (uq_cnt_q == UQ_FULL_CNT);
  assign uq_empty = (uq_cnt_q == '0);
  assign lk_ready = (state_q == S_IDLE) && !uq_full;
`ifdef PHT_INIT_EN
  assign up_ready = !uq_full && (state_q != S_INIT);
`else
  assign up_ready = !uq_full;
`endif
  assign push   = up_valid && up_ready;
  assign lk_go  = lk_valid && lk_ready;
  // A full FIFO blocks lk_ready, so a lookup can only win while space is left.
  assign upd_go = (state_q == S_IDLE) && !lk_go && !uq_empty;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (upd_go) state_d = S_UPD_RD;
      S_UPD_RD: state_d = S_UPD_WR;
      S_UPD_WR: state_d = S_IDLE;
`ifdef PHT_INIT_EN
      S_INIT:   if (init_cnt_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // The counter read returns in the write cycle itself. The write data is
  // therefore formed from tab_rd_data and the registered write enable.
  always_comb begin
    tab_up_data = '0;
    if (tab_wr_en_q) begin
`ifdef PHT_INIT_EN
      tab_up_data = init_wr_q ? CNT_W'(1) : sat_step(tab_rd_data, hold_taken_q);
`else
      tab_up_data = sat_step(tab_rd_data, hold_taken_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      uq_set[wr_ptr_q]   <= up_set;
      uq_idx[wr_ptr_q]   <= up_idx;
      uq_taken[wr_ptr_q] <= up_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef PHT_INIT_EN
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      init_wr_q  <= 1'b0;
`else
      state_q    <= S_IDLE;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      uq_cnt_q     <= '0;
      hold_taken_q <= 1'b0;
      tab_wr_en_q  <= 1'b0;
      tab_set_q    <= '0;
      tab_idx_q    <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_pend_q  <= lk_go;
      rsp_valid_q <= rsp_pend_q;
      tab_wr_en_q <= (state_q == S_UPD_RD);
`ifdef PHT_INIT_EN
      init_wr_q <= 1'b0;
      if (state_q == S_INIT) begin
        tab_wr_en_q              <= 1'b1;
        init_wr_q                <= 1'b1;
        {tab_set_q, tab_idx_q}   <= init_cnt_q;
        init_cnt_q               <= init_cnt_q + 1'b1;
      end
`endif
      if (lk_go) begin
        tab_set_q <= lk_set;
        tab_idx_q <= lk_idx;
      end else if (upd_go) begin
        tab_set_q    <= uq_set[rd_ptr_q];
        tab_idx_q    <= uq_idx[rd_ptr_q];
        hold_taken_q <= uq_taken[rd_ptr_q];
      end
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (upd_go) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, upd_go})
        2'b10:   uq_cnt_q <= uq_cnt_q + 1'b1;
        2'b01:   uq_cnt_q <= uq_cnt_q - 1'b1;
        default: uq_cnt_q <= uq_cnt_q;
      endcase
    end
  end

  assign tab_wr_en    = tab_wr_en_q;
  assign tab_set_addr = tab_set_q;
  assign tab_tab_addr = tab_idx_q;
  assign lk_rsp_valid = rsp_valid_q;
  assign lk_rsp_cnt   = rsp_valid_q ? tab_rd_data : '0;
  assign lk_rsp_taken = lk_rsp_cnt[CNT_W-1];
  assign busy         = (state_q != S_IDLE) || !uq_empty;

endmodule
